// File: rtl/clock_display_pkg.sv
// Shared types and constants for the desk-clock display path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package clock_display_pkg;

  // Frame sequencer states, in frame order.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SELECT   = 3'd1,
    ST_SHIFT_LO = 3'd2,
    ST_SHIFT_HI = 3'd3,
    ST_LATCH    = 3'd4,
    ST_DONE     = 3'd5
  } drv_state_t;

  // Select code the segment mux decodes as "no digit", blanking the display.
  localparam logic [2:0] SEG_SELECT_BLANK = 3'h7;
  localparam int         NUM_DIGITS       = 6;
  localparam int         BITS_PER_DIGIT   = 8;

endpackage

// File: rtl/serial_clk_divider.sv
// Reloadable phase timer: o_tick fires once, CLK_DIV cycles after i_reload.
// Latency: tick is high in the CLK_DIV-th cycle after the reload cycle.
// Backpressure: none; a reload always restarts the count.
//
// Ports:
//   i_clk, i_reset_n : clock, synchronous active-low reset
//   i_reload         : restart the phase (asserted in the cycle before the phase begins)
//   o_tick           : one-cycle strobe marking the last cycle of the phase
module serial_clk_divider #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_reload,
  output logic o_tick
);

  localparam logic [7:0] RELOAD_VAL = 8'(CLK_DIV - 1);

  logic [7:0] count_q;
  logic       armed_q;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      count_q <= 8'd0;
      armed_q <= 1'b0;
    end else if (i_reload) begin
      count_q <= RELOAD_VAL;
      armed_q <= 1'b1;
    end else begin
      if (count_q != 8'd0) begin
        count_q <= count_q - 8'd1;
      end
      // Disarm once the tick has been delivered so it stays one cycle wide.
      if (count_q == 8'd0) begin
        armed_q <= 1'b0;
      end
    end
  end

  assign o_tick = armed_q && (count_q == 8'd0);

endmodule

// File: rtl/segment_shift_driver.sv
// Frame sequencer: walks six mux digits, shifts 48 bits MSB-first into a 595 chain, latches.
// Latency: 6*(2+16*CLK_DIV)+CLK_DIV cycles from the accepting edge to o_frame_done.
// Backpressure: none; i_refresh outside IDLE is dropped, i_en low aborts to IDLE next cycle.
//
// Ports:
//   i_clk, i_reset_n  : clock, synchronous active-low reset
//   i_en              : driver enable
//   i_refresh         : one-cycle frame start strobe
//   i_led_segments    : 7-segment pattern returned by the digit mux
//   i_dp_mask         : decimal point per digit (bit d -> digit d)
//   o_segment_select  : digit index to the mux (3'h7 = blank)
//   o_serial_data/clk : shift-register data and clock (sampled on clk rise)
//   o_serial_latch    : storage-register latch pulse
//   o_busy            : frame in progress
//   o_frame_done      : one-cycle frame completion pulse
module segment_shift_driver
  import clock_display_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned NUM_DIGITS = 6
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_en,
  input  logic       i_refresh,
  input  logic [6:0] i_led_segments,
  input  logic [5:0] i_dp_mask,
  output logic [2:0] o_segment_select,
  output logic       o_serial_data,
  output logic       o_serial_clk,
  output logic       o_serial_latch,
  output logic       o_busy,
  output logic       o_frame_done
);

  localparam logic [2:0] LAST_DIGIT = 3'(NUM_DIGITS - 1);
  localparam logic [2:0] FIRST_BIT  = 3'(BITS_PER_DIGIT - 1);

  drv_state_t state_q, state_d;
  logic [2:0] digit_q, digit_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] byte_q, byte_d;
  logic       sel_phase_q, sel_phase_d;

  logic [2:0] seg_sel_q, seg_sel_d;
  logic       sdat_q, sdat_d;
  logic       sclk_q, sclk_d;
  logic       latch_q, latch_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic       reload;
  logic       tick;

  serial_clk_divider #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_reload  (reload),
    .o_tick    (tick)
  );

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    digit_d     = digit_q;
    bit_d       = bit_q;
    byte_d      = byte_q;
    sel_phase_d = sel_phase_q;

    case (state_q)
      ST_IDLE: begin
        if (i_refresh && i_en) begin
          digit_d     = 3'd0;
          sel_phase_d = 1'b0;
          state_d     = ST_SELECT;
        end
      end
      ST_SELECT: begin
        // First cycle lets the mux register the select, second lets it decode.
        if (sel_phase_q) begin
          byte_d  = {i_dp_mask[digit_q], i_led_segments};
          bit_d   = FIRST_BIT;
          state_d = ST_SHIFT_LO;
        end else begin
          sel_phase_d = 1'b1;
        end
      end
      ST_SHIFT_LO: begin
        if (tick) begin
          state_d = ST_SHIFT_HI;
        end
      end
      ST_SHIFT_HI: begin
        if (tick) begin
          if (bit_q != 3'd0) begin
            bit_d   = bit_q - 3'd1;
            state_d = ST_SHIFT_LO;
          end else if (digit_q != LAST_DIGIT) begin
            digit_d     = digit_q + 3'd1;
            sel_phase_d = 1'b0;
            state_d     = ST_SELECT;
          end else begin
            state_d = ST_LATCH;
          end
        end
      end
      ST_LATCH: begin
        if (tick) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Enable low abandons the frame without latching.
    if ((state_q != ST_IDLE) && !i_en) begin
      state_d = ST_IDLE;
    end
  end

  // Output values for the coming cycle, derived from the next state so that
  // every output leaves a flop.
  always_comb begin
    reload    = (state_d != state_q);

    seg_sel_d = seg_sel_q;
    if (state_d == ST_IDLE) begin
      seg_sel_d = SEG_SELECT_BLANK;
    end else if (state_d == ST_SELECT) begin
      seg_sel_d = digit_d;
    end

    sdat_d  = 1'b0;
    if ((state_d == ST_SHIFT_LO) || (state_d == ST_SHIFT_HI)) begin
      sdat_d = byte_d[bit_d];
    end
    sclk_d  = (state_d == ST_SHIFT_HI);
    latch_d = (state_d == ST_LATCH);
    done_d  = (state_d == ST_DONE);

    // Busy trails the state by one cycle: high from the cycle after the
    // accepting edge up to and including the DONE cycle's predecessor window.
    busy_d  = i_en && (state_q != ST_IDLE) && (state_q != ST_DONE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q     <= ST_IDLE;
      digit_q     <= 3'd0;
      bit_q       <= 3'd0;
      byte_q      <= 8'd0;
      sel_phase_q <= 1'b0;
      seg_sel_q   <= SEG_SELECT_BLANK;
      sdat_q      <= 1'b0;
      sclk_q      <= 1'b0;
      latch_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      digit_q     <= digit_d;
      bit_q       <= bit_d;
      byte_q      <= byte_d;
      sel_phase_q <= sel_phase_d;
      seg_sel_q   <= seg_sel_d;
      sdat_q      <= sdat_d;
      sclk_q      <= sclk_d;
      latch_q     <= latch_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign o_segment_select = seg_sel_q;
  assign o_serial_data    = sdat_q;
  assign o_serial_clk     = sclk_q;
  assign o_serial_latch   = latch_q;
  assign o_busy           = busy_q;
  assign o_frame_done     = done_q;

endmodule

// File: tb/tb_segment_shift_driver.sv
// Bench for segment_shift_driver: two instances (CLK_DIV=1 and CLK_DIV=2),
// each with a registered digit-mux model, a 48-bit 595 chain model and a
// protocol monitor.
module tb_segment_shift_driver;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] en_v;
  logic [1:0] refresh_v;
  logic [5:0] dp_mask;
  logic       pat;
  logic       chk_on;

  int tests = 0;
  int fails = 0;

  wire [1:0][2:0]  sel_w;
  wire [1:0]       sdat_w, sclk_w, slat_w, busy_w, done_w;
  wire [1:0][47:0] latched_w;
  wire [1:0][31:0] latch_cnt_w, done_cnt_w, viol_w;

  localparam logic [47:0] EXP_P0 = 48'hC04142434445;
  localparam logic [47:0] EXP_P1 = 48'h7FFE7DFC7BFA;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [6:0]  led_q;
    logic [47:0] sr = '0;
    logic [47:0] latched = '0;
    int          latch_cnt = 0;
    int          done_cnt = 0;
    int          viol = 0;
    logic        prev_sclk = 1'b0;
    logic        prev_sdat = 1'b0;
    logic [2:0]  prev_sel = 3'h7;

    segment_shift_driver #(
      .CLK_DIV    (g + 1),
      .NUM_DIGITS (6)
    ) u_dut (
      .i_clk            (clk),
      .i_reset_n        (rst_n),
      .i_en             (en_v[g]),
      .i_refresh        (refresh_v[g]),
      .i_led_segments   (led_q),
      .i_dp_mask        (dp_mask),
      .o_segment_select (sel_w[g]),
      .o_serial_data    (sdat_w[g]),
      .o_serial_clk     (sclk_w[g]),
      .o_serial_latch   (slat_w[g]),
      .o_busy           (busy_w[g]),
      .o_frame_done     (done_w[g])
    );

    // Digit mux: one register stage between select and pattern.
    always @(posedge clk) begin
      if (sel_w[g] < 3'd6)
        led_q <= pat ? (7'h7F ^ {4'd0, sel_w[g]}) : (7'h40 | {4'd0, sel_w[g]});
      else
        led_q <= 7'h00;
    end

    always @(posedge sclk_w[g]) sr <= {sr[46:0], sdat_w[g]};

    always @(posedge slat_w[g]) begin
      latched   <= sr;
      latch_cnt <= latch_cnt + 1;
    end

    always @(negedge clk) begin
      if (done_w[g] === 1'b1) done_cnt = done_cnt + 1;
      if (chk_on) begin
        if (prev_sclk && sclk_w[g] && (sdat_w[g] !== prev_sdat)) viol = viol + 1;
        if (slat_w[g] && sclk_w[g]) viol = viol + 1;
        if ((sel_w[g] !== prev_sel) && (sel_w[g] !== 3'h7) &&
            !((sel_w[g] == 3'(prev_sel + 3'd1)) && !sclk_w[g] && !sdat_w[g]))
          viol = viol + 1;
      end
      prev_sclk = sclk_w[g];
      prev_sdat = sdat_w[g];
      prev_sel  = sel_w[g];
    end

    assign latched_w[g]   = latched;
    assign latch_cnt_w[g] = latch_cnt;
    assign done_cnt_w[g]  = done_cnt;
    assign viol_w[g]      = viol;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst_n = 1'b0; en_v = '0; refresh_v = '0; dp_mask = '0; pat = 1'b0; chk_on = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (sel_w[i] !== 3'h7) begin
        fails++; $display("FAIL reset_sel[%0d]: got %0h want 7", i, sel_w[i]);
      end
      tests++;
      if ({sdat_w[i], sclk_w[i], slat_w[i], busy_w[i], done_w[i]} !== 5'b0) begin
        fails++; $display("FAIL reset_outputs[%0d]: got %b want 00000", i,
                          {sdat_w[i], sclk_w[i], slat_w[i], busy_w[i], done_w[i]});
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk_on = 1'b1;
  endtask

  task automatic test_frame_data(input int inst, input logic p, input logic [5:0] dp,
                                 input logic [47:0] exp);
    int lc0, dc0, k, cd, exp_len;
    cd = inst + 1;
    exp_len = 6 * (2 + 16 * cd) + cd;
    pat = p; dp_mask = dp; en_v[inst] = 1'b1;
    lc0 = latch_cnt_w[inst]; dc0 = done_cnt_w[inst];
    refresh_v[inst] = 1'b1;
    @(negedge clk);
    refresh_v[inst] = 1'b0;
    k = 0;
    while (!done_w[inst] && k < 2000) begin
      @(negedge clk); k++;
    end
    tests++;
    if (k != exp_len) begin
      fails++; $display("FAIL frame_len[%0d]: got %0d want %0d", inst, k, exp_len);
    end
    repeat (2) @(negedge clk);
    tests++;
    if (latched_w[inst] !== exp) begin
      fails++; $display("FAIL frame_bits[%0d]: got %h want %h", inst, latched_w[inst], exp);
    end
    tests++;
    if (latch_cnt_w[inst] - lc0 != 1) begin
      fails++; $display("FAIL frame_latches[%0d]: got %0d want 1", inst, latch_cnt_w[inst] - lc0);
    end
    tests++;
    if (done_cnt_w[inst] - dc0 != 1) begin
      fails++; $display("FAIL frame_dones[%0d]: got %0d want 1", inst, done_cnt_w[inst] - dc0);
    end
  endtask

  task automatic test_frame_length();
    int first_done, busy_cnt;
    pat = 1'b0; dp_mask = 6'b000001; en_v[0] = 1'b1;
    first_done = -1; busy_cnt = 0;
    refresh_v[0] = 1'b1;
    @(negedge clk);
    refresh_v[0] = 1'b0;
    for (int k = 0; k < 150; k++) begin
      if (done_w[0] && first_done < 0) first_done = k;
      if (busy_w[0]) busy_cnt++;
      @(negedge clk);
    end
    tests++;
    if (first_done != 109) begin
      fails++; $display("FAIL len_div1_done: got %0d want 109", first_done);
    end
    tests++;
    if (busy_cnt != 109) begin
      fails++; $display("FAIL len_div1_busy: got %0d want 109", busy_cnt);
    end
  endtask

  task automatic test_refresh_hold();
    int n_done, n_rise, first, second, lc0, k;
    logic prev_busy;
    pat = 1'b0; dp_mask = 6'b000001; en_v[0] = 1'b1;
    n_done = 0; n_rise = 0; first = -1; second = -1;
    lc0 = latch_cnt_w[0];
    prev_busy = busy_w[0];
    refresh_v[0] = 1'b1;
    for (int j = 0; j < 300; j++) begin
      @(negedge clk);
      if (done_w[0]) begin
        if (n_done == 0) first = j;
        else if (n_done == 1) second = j;
        n_done++;
      end
      if (busy_w[0] && !prev_busy) n_rise++;
      prev_busy = busy_w[0];
    end
    refresh_v[0] = 1'b0;
    tests++;
    if (first != 109 || second != 220) begin
      fails++; $display("FAIL hold_done_pos: got %0d,%0d want 109,220", first, second);
    end
    tests++;
    if (n_done != 2) begin
      fails++; $display("FAIL hold_done_cnt: got %0d want 2", n_done);
    end
    tests++;
    if (n_rise != 3) begin
      fails++; $display("FAIL hold_starts: got %0d want 3", n_rise);
    end
    k = 0;
    while (!done_w[0] && k < 200) begin
      @(negedge clk); k++;
    end
    repeat (2) @(negedge clk);
    tests++;
    if (latch_cnt_w[0] - lc0 != 3) begin
      fails++; $display("FAIL hold_latches: got %0d want 3", latch_cnt_w[0] - lc0);
    end
    tests++;
    if (latched_w[0] !== EXP_P0) begin
      fails++; $display("FAIL hold_bits: got %h want %h", latched_w[0], EXP_P0);
    end
  endtask

  task automatic test_enable_drop();
    int lc0, dc0, k;
    pat = 1'b0; dp_mask = 6'b000001; en_v[1] = 1'b1;
    lc0 = latch_cnt_w[1]; dc0 = done_cnt_w[1];
    refresh_v[1] = 1'b1;
    @(negedge clk);
    refresh_v[1] = 1'b0;
    k = 0;
    while (sel_w[1] !== 3'd3 && k < 1000) begin
      @(negedge clk); k++;
    end
    tests++;
    if (sel_w[1] !== 3'd3) begin
      fails++; $display("FAIL en_reach_digit3: got %0h want 3", sel_w[1]);
    end
    repeat (10) @(negedge clk);
    en_v[1] = 1'b0;
    @(negedge clk);
    tests++;
    if (sel_w[1] !== 3'h7) begin
      fails++; $display("FAIL en_drop_sel: got %0h want 7", sel_w[1]);
    end
    tests++;
    if ({sdat_w[1], sclk_w[1], slat_w[1], busy_w[1], done_w[1]} !== 5'b0) begin
      fails++; $display("FAIL en_drop_outputs: got %b want 00000",
                        {sdat_w[1], sclk_w[1], slat_w[1], busy_w[1], done_w[1]});
    end
    repeat (300) @(negedge clk);
    tests++;
    if ((latch_cnt_w[1] - lc0 != 0) || (done_cnt_w[1] - dc0 != 0)) begin
      fails++; $display("FAIL en_drop_no_latch: got latch %0d done %0d want 0 0",
                        latch_cnt_w[1] - lc0, done_cnt_w[1] - dc0);
    end
    // Refresh while disabled must not start a frame.
    refresh_v[1] = 1'b1;
    @(negedge clk);
    refresh_v[1] = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (busy_w[1] !== 1'b0 || sel_w[1] !== 3'h7) begin
      fails++; $display("FAIL en_low_refresh: got busy %b sel %0h want 0 7", busy_w[1], sel_w[1]);
    end
    en_v[1] = 1'b1;
  endtask

  task automatic test_reset_mid();
    int lc0, dc0;
    pat = 1'b0; dp_mask = 6'b000001; en_v[1] = 1'b1;
    lc0 = latch_cnt_w[1]; dc0 = done_cnt_w[1];
    refresh_v[1] = 1'b1;
    @(negedge clk);
    refresh_v[1] = 1'b0;
    repeat (50) @(negedge clk);
    tests++;
    if (busy_w[1] !== 1'b1) begin
      fails++; $display("FAIL rst_mid_busy_before: got %b want 1", busy_w[1]);
    end
    rst_n = 1'b0;
    @(negedge clk);
    tests++;
    if (sel_w[1] !== 3'h7) begin
      fails++; $display("FAIL rst_mid_sel: got %0h want 7", sel_w[1]);
    end
    tests++;
    if ({sdat_w[1], sclk_w[1], slat_w[1], busy_w[1], done_w[1]} !== 5'b0) begin
      fails++; $display("FAIL rst_mid_outputs: got %b want 00000",
                        {sdat_w[1], sclk_w[1], slat_w[1], busy_w[1], done_w[1]});
    end
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    tests++;
    if ((latch_cnt_w[1] - lc0 != 0) || (done_cnt_w[1] - dc0 != 0)) begin
      fails++; $display("FAIL rst_mid_no_latch: got latch %0d done %0d want 0 0",
                        latch_cnt_w[1] - lc0, done_cnt_w[1] - dc0);
    end
  endtask

  task automatic test_protocol();
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (viol_w[i] != 0) begin
        fails++; $display("FAIL protocol[%0d]: got %0d violations want 0", i, viol_w[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame_data(1, 1'b0, 6'b000001, EXP_P0);
    test_frame_data(1, 1'b1, 6'b101010, EXP_P1);
    test_frame_data(0, 1'b0, 6'b000001, EXP_P0);
    test_frame_length();
    test_refresh_hold();
    test_enable_drop();
    test_reset_mid();
    test_frame_data(1, 1'b1, 6'b101010, EXP_P1);
    test_protocol();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/segment_shift_driver.md
# segment_shift_driver

Frame sequencer for the desk-clock display. It steps `bcd_segment_mux` through the six digits and captures each returned 7-segment pattern plus a decimal-point bit. It shifts the resulting 48 bits serially into an external 74HC595-style chain, then pulses the latch. It sits between the display refresh tick and the board's shift-register pins.

## Interface
Parameters:
- `CLK_DIV`, default 4: `i_clk` cycles per serial-clock half period; legal range 1..255.
- `NUM_DIGITS`, default 6: digits per frame; fixed at 6 for this design.

Ports:
- `i_clk`, in, 1: system clock.
- `i_reset_n`, in, 1: reset, synchronous, active-low.
- `i_en`, in, 1: driver enable; low aborts any frame.
- `i_refresh`, in, 1: one-cycle frame start strobe.
- `i_led_segments`, in, 7: segment pattern from `bcd_segment_mux.o_led_out`.
- `i_dp_mask`, in, 6: decimal point per digit; bit d belongs to digit d.
- `o_segment_select`, out, 3: digit index to `bcd_segment_mux.i_segment_select`.
- `o_serial_data`, out, 1: shift-register data.
- `o_serial_clk`, out, 1: shift-register clock; data is sampled on its rising edge.
- `o_serial_latch`, out, 1: storage-register latch pulse.
- `o_busy`, out, 1: high while a frame is in progress.
- `o_frame_done`, out, 1: one-cycle pulse when a frame completes.

## Operation
- States: IDLE, SELECT, SHIFT_LO, SHIFT_HI, LATCH, DONE.
- IDLE:
  - `o_segment_select`=3'h7, which the mux treats as invalid, so the display blanks.
  - `o_busy`=0; serial outputs are 0.
  - If `i_refresh` and `i_en` are both high, set digit=0 and go to SELECT.
- SELECT:
  - Drive `o_segment_select`=digit for exactly 2 cycles. The mux needs 1 cycle for its register and 1 for the decode.
  - On the 2nd cycle, capture byte = {`i_dp_mask`[digit], `i_led_segments`[6:0]}, set bit=7, go to SHIFT_LO.
- Per bit, MSB first, so the DP bit goes out first:
  - SHIFT_LO: `o_serial_data`=byte[bit], `o_serial_clk`=0, held for `CLK_DIV` cycles, then go to SHIFT_HI.
  - SHIFT_HI: `o_serial_clk`=1 with data unchanged, held for `CLK_DIV` cycles.
  - At the end of SHIFT_HI: if bit>0, decrement bit and return to SHIFT_LO; else if digit<5, increment digit and return to SELECT; else go to LATCH.
- LATCH: `o_serial_latch`=1 and `o_serial_clk`=0 for `CLK_DIV` cycles, then go to DONE.
- DONE: `o_frame_done`=1 for 1 cycle, then return to IDLE.
- Digit order is 0 (seconds LSB) through 5 (hours MSB). Digit 5's byte therefore ends up nearest the chain input.
- `i_refresh` outside IDLE is ignored; nothing is queued.
- `i_en` low in any non-IDLE state:
  - Next cycle, go to IDLE with outputs at their idle values.
  - No latch pulse and no `o_frame_done`.
- `i_dp_mask` and `i_led_segments` are sampled only at the SELECT capture cycle.
- Counters:
  - Divider is 8 bits and reloads at every state entry.
  - Bit counter is 3 bits; digit counter is 3 bits.
  - All counters are reset to 0.

## Timing
- Reset (synchronous, `i_reset_n`=0 at a clock edge):
  - Next cycle: state IDLE, `o_segment_select`=3'h7.
  - `o_serial_data`, `o_serial_clk`, `o_serial_latch`, `o_busy` and `o_frame_done` are all 0.
  - Reset mid-frame behaves the same way and produces no latch pulse.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `o_busy` rises the cycle after `i_refresh` is accepted and falls the cycle after DONE.
- Frame length from the accepting edge to the `o_frame_done` pulse is 6·(2 + 16·`CLK_DIV`) + `CLK_DIV` cycles, counting the DONE cycle.
  - `CLK_DIV`=1: 109 cycles.
  - `CLK_DIV`=4: 400 cycles.
- Data setup before the `o_serial_clk` rising edge is `CLK_DIV` cycles; hold after it is `CLK_DIV` cycles.
- If `i_refresh` coincides with DONE, it is ignored.

## Structure
- Shared package `clock_display_pkg`:
  - state enum.
  - `SEG_SELECT_BLANK`=3'h7.
  - `NUM_DIGITS`=6.
  - `BITS_PER_DIGIT`=8.
- One natural sub-module, `serial_clk_divider`:
  - Reloadable down-counter that produces a 1-cycle `tick` after `CLK_DIV` cycles.
  - The FSM uses it to time the SHIFT_LO, SHIFT_HI and LATCH phases.

## Test plan
- Reset mid-frame (`CLK_DIV`=2, reset at cycle 50) → next cycle all outputs 0, select=7, and no latch follows.
- Static mux model, digit d returns 7'h40|d, `i_dp_mask`=6'b000001 → shift-register model holds 48 bits:
  - digit 0 byte = 8'hC0.
  - digits 1–5 bytes = 8'h41..8'h45.
  - exactly one latch pulse.
- `CLK_DIV`=1, single `i_refresh` → `o_frame_done` pulses exactly 109 cycles later; `o_busy` is high for 109 cycles.
- `i_refresh` held high for 300 cycles (`CLK_DIV`=1) → frames restart only from IDLE:
  - 2 complete frames in the first 220 cycles.
  - `i_refresh` asserted during busy never perturbs the sequence.
- `i_en` dropped during digit 3 → next cycle IDLE and select=7; no `o_serial_latch` and no `o_frame_done`.
- Protocol checker across all runs:
  - `o_serial_data` never changes while `o_serial_clk`=1.
  - `o_serial_latch` is never high at the same time as `o_serial_clk`.
  - `o_segment_select` changes only when entering SELECT or IDLE.
